// File: rtl/ecg_ram_ctrl.sv
// ECG capture buffer controller: circular 1024-sample write pointer, freeze-for-display FSM
// and oldest-first read addressing. Optional input decimation is enabled by ECG_DECIM_EN.
module ecg_ram_ctrl #(
  parameter int unsigned DECIM = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [9:0] sample_data,
  input  logic       freeze,
  input  logic       rd_req,
  input  logic [9:0] rd_col,
  output logic       ram_we,
  output logic [9:0] ram_addr_in,
  output logic [9:0] ram_din,
  output logic [9:0] ram_addr_out,
  input  logic [9:0] ram_dout,
  output logic       rd_valid,
  output logic [9:0] rd_data,
  output logic       buf_full,
  output logic       frozen
);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FROZEN
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] wr_ptr;
  logic       full_q;
  logic       accept;
  logic       wr_en;
  logic [9:0] rd_base;
  logic       rd_valid_q;
  logic       byp_hit_q;
  logic [9:0] byp_data_q;

  if (DECIM < 2 || DECIM > 16) begin : g_decim_range
    $error("ecg_ram_ctrl: DECIM must be in 2..16");
  end

  // freeze wins over a same-cycle sample; nothing is accepted while FROZEN or in reset
  assign accept = sample_valid && !rst && !freeze && (state != FROZEN);

`ifdef ECG_DECIM_EN
  logic [3:0] dec_cnt;
  logic       dec_hit;

  assign dec_hit = (dec_cnt == 4'(DECIM - 1));
  assign wr_en   = accept && dec_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if (accept) begin
      dec_cnt <= dec_hit ? '0 : dec_cnt + 4'd1;
    end
  end
`else
  assign wr_en = accept;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (freeze)
          state_nxt = FROZEN;
        else if (wr_en && wr_ptr == '1)
          state_nxt = RUN;
      end
      RUN: begin
        if (freeze)
          state_nxt = FROZEN;
      end
      FROZEN: begin
        if (!freeze)
          state_nxt = full_q ? RUN : FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wr_ptr     <= '0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      state      <= state_nxt;
      if (wr_en)
        wr_ptr <= wr_ptr + 10'd1;
      if (state == FILL && wr_en && wr_ptr == '1)
        full_q <= 1'b1;
      rd_valid_q <= rd_req;
      // The RAM's read-during-write behaviour is unknown, so a colliding read takes the new data here
      byp_hit_q  <= rd_req && wr_en && (ram_addr_out == wr_ptr);
      byp_data_q <= sample_data;
    end
  end

  assign rd_base      = (state == FILL) ? '0 : wr_ptr;
  assign ram_we       = wr_en;
  assign ram_addr_in  = wr_ptr;
  assign ram_din      = sample_data;
  assign ram_addr_out = rd_base + rd_col;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_valid_q ? (byp_hit_q ? byp_data_q : ram_dout) : '0;
  assign buf_full     = full_q;
  assign frozen       = (state == FROZEN);

endmodule

// File: tb/tb_ecg_ram_ctrl.sv
// Testbench for ecg_ram_ctrl: behavioural 1024x10 RAM, vector table plus directed sequences.
module tb_ecg_ram_ctrl;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [9:0] sample_data;
  logic       freeze;
  logic       rd_req;
  logic [9:0] rd_col;
  logic       ram_we;
  logic [9:0] ram_addr_in;
  logic [9:0] ram_din;
  logic [9:0] ram_addr_out;
  logic [9:0] ram_dout;
  logic       rd_valid;
  logic [9:0] rd_data;
  logic       buf_full;
  logic       frozen;

  int errors = 0;
  int checks = 0;

  ecg_ram_ctrl #(.DECIM(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .freeze       (freeze),
    .rd_req       (rd_req),
    .rd_col       (rd_col),
    .ram_we       (ram_we),
    .ram_addr_in  (ram_addr_in),
    .ram_din      (ram_din),
    .ram_addr_out (ram_addr_out),
    .ram_dout     (ram_dout),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .buf_full     (buf_full),
    .frozen       (frozen)
  );

  // Synchronous RAM, old data returned on a read/write collision
  logic [9:0] mem [1024];
  always @(posedge clk) begin
    if (ram_we)
      mem[ram_addr_in] <= ram_din;
    ram_dout <= mem[ram_addr_out];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk10(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checks
  task automatic cyc(input logic r, input logic sv, input logic [9:0] d,
                     input logic fz, input logic rq, input logic [9:0] col);
    @(negedge clk);
    rst          = r;
    sample_valid = sv;
    sample_data  = d;
    freeze       = fz;
    rd_req       = rq;
    rd_col       = col;
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       sv;
    logic [9:0] d;
    logic       fz;
    logic       rq;
    logic [9:0] col;
    logic       we;
    logic [9:0] a_in;
    logic [9:0] a_out;
    logic       rv;
    logic [9:0] rd;
    logic       full;
    logic       frz;
  } vec_t;

  vec_t tv [16];

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_data = '0;
    freeze = 1'b0; rd_req = 1'b0; rd_col = '0;

`ifdef ECG_DECIM_EN
    begin
      int nw;
      nw = 0;
      cyc(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
      for (int i = 1; i <= 12; i++) begin
        cyc(1'b0, 1'b1, 10'(i), 1'b0, 1'b0, 10'd0);
        chk1("decim_we", ram_we, (i % 4) == 0);
        if ((i % 4) == 0) begin
          chk10("decim_addr", ram_addr_in, 10'(i / 4 - 1));
          chk10("decim_data", ram_din, 10'(i));
        end
        if (ram_we) nw++;
      end
      chk10("decim_writes", 10'(nw), 10'd3);
    end
`else
    //           rst   sv    d        fz    rq    col      we    a_in    a_out   rv    rd      full  frz
    tv[0]  = '{1'b1, 1'b1, 10'd7, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd0, 1'b1, 10'd1, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 1'b1, 10'd2, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 10'd4, 1'b0, 1'b0, 10'd0, 1'b1, 10'd3, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 1'b1, 10'd4, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd2, 1'b0, 10'd5, 10'd2, 1'b0, 10'd0, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd5, 10'd0, 1'b1, 10'd3, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 10'd9, 1'b1, 1'b0, 10'd0, 1'b0, 10'd5, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 10'd9, 1'b1, 1'b0, 10'd1, 1'b0, 10'd5, 10'd6, 1'b0, 10'd0, 1'b0, 1'b1};
    tv[10] = '{1'b0, 1'b1, 10'd9, 1'b0, 1'b0, 10'd1, 1'b0, 10'd5, 10'd6, 1'b0, 10'd0, 1'b0, 1'b1};
    tv[11] = '{1'b0, 1'b1, 10'd6, 1'b0, 1'b0, 10'd3, 1'b1, 10'd5, 10'd3, 1'b0, 10'd0, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd5, 1'b0, 10'd6, 10'd5, 1'b0, 10'd0, 1'b0, 1'b0};
    tv[13] = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd0, 1'b0, 10'd6, 10'd0, 1'b1, 10'd6, 1'b0, 1'b0};
    tv[14] = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd6, 10'd0, 1'b1, 10'd1, 1'b0, 1'b0};
    tv[15] = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd6, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0};

    cyc(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(tv[i].rst, tv[i].sv, tv[i].d, tv[i].fz, tv[i].rq, tv[i].col);
      chk1 ("tv_we",       ram_we,       tv[i].we);
      chk10("tv_addr_in",  ram_addr_in,  tv[i].a_in);
      chk10("tv_addr_out", ram_addr_out, tv[i].a_out);
      chk1 ("tv_rd_valid", rd_valid,     tv[i].rv);
      chk10("tv_rd_data",  rd_data,      tv[i].rd);
      chk1 ("tv_buf_full", buf_full,     tv[i].full);
      chk1 ("tv_frozen",   frozen,       tv[i].frz);
    end

    // Wrap-around: 1030 samples, value = index
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 1030; i++) begin
      cyc(1'b0, 1'b1, 10'(i), 1'b0, 1'b0, 10'd0);
      chk1 ("wrap_we", ram_we, 1'b1);
      chk10("wrap_addr_in", ram_addr_in, 10'(i));
      if (i == 1023) chk1("full_before", buf_full, 1'b0);
      if (i == 1024) chk1("full_after", buf_full, 1'b1);
    end
    cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd0);
    chk10("run_addr_col0", ram_addr_out, 10'd6);
    cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd1023);
    chk10("run_addr_col1023", ram_addr_out, 10'd5);
    chk10("oldest_data", rd_data, 10'd6);
    cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    chk10("newest_data", rd_data, 10'd5);

    // Read and write of address 6 in the same cycle
    cyc(1'b0, 1'b1, 10'h2A5, 1'b0, 1'b1, 10'd0);
    chk1 ("coll_we", ram_we, 1'b1);
    chk10("coll_addr_out", ram_addr_out, 10'd6);
    cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    chk1 ("coll_rd_valid", rd_valid, 1'b1);
    chk10("coll_rd_data", rd_data, 10'h2A5);

    // Freeze in RUN with a coincident sample
    cyc(1'b0, 1'b1, 10'h111, 1'b1, 1'b0, 10'd0);
    chk1("frz_we", ram_we, 1'b0);
    chk1("frz_pre", frozen, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b1, 10'(k), 1'b1, 1'b0, 10'd0);
      chk1 ("frz_hold_we", ram_we, 1'b0);
      chk1 ("frz_hold_frozen", frozen, 1'b1);
      chk10("frz_hold_ptr", ram_addr_in, 10'd7);
    end
    cyc(1'b0, 1'b1, 10'h0AA, 1'b0, 1'b0, 10'd0);
    chk1("unfrz_drop_we", ram_we, 1'b0);
    chk1("unfrz_frozen", frozen, 1'b1);
    cyc(1'b0, 1'b1, 10'h0BB, 1'b0, 1'b0, 10'd0);
    chk1 ("resume_frozen", frozen, 1'b0);
    chk1 ("resume_we", ram_we, 1'b1);
    chk10("resume_addr_in", ram_addr_in, 10'd7);
    chk10("resume_run_base", ram_addr_out, 10'd7);
    chk1 ("resume_full", buf_full, 1'b1);

    // Back-to-back reads, columns 0..7 map to addresses 8..15
    for (int k = 0; k <= 8; k++) begin
      cyc(1'b0, 1'b0, 10'd0, 1'b0, (k < 8), 10'(k));
      if (k > 0) begin
        chk1 ("b2b_valid", rd_valid, 1'b1);
        chk10("b2b_data", rd_data, 10'(8 + k - 1));
      end
    end
    cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    chk1 ("b2b_end_valid", rd_valid, 1'b0);
    chk10("b2b_end_data", rd_data, 10'd0);

    // Reset while a read is in flight, write pointer at 300
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 300; i++)
      cyc(1'b0, 1'b1, 10'(i), 1'b0, 1'b0, 10'd0);
    cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd0);
    chk10("pre_rst_ptr", ram_addr_in, 10'd300);
    cyc(1'b1, 1'b1, 10'h3FF, 1'b0, 1'b1, 10'd0);
    chk1("rst_we", ram_we, 1'b0);
    cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    chk1 ("rst_rd_valid", rd_valid, 1'b0);
    chk10("rst_rd_data", rd_data, 10'd0);
    chk10("rst_ptr", ram_addr_in, 10'd0);
    chk10("rst_fill_base", ram_addr_out, 10'd0);
    chk1 ("rst_full", buf_full, 1'b0);
    chk1 ("rst_frozen", frozen, 1'b0);
    cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd5);
    cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    chk1 ("keep_valid", rd_valid, 1'b1);
    chk10("keep_data", rd_data, 10'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecg_ram_ctrl.md
ECG_RAM_CTRL -- requirements
Module: ecg_ram_ctrl

Interface
REQ-001 The block SHALL have one parameter: DECIM, default 4, decimation factor (2..16) used only when ECG_DECIM_EN is defined.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe, new ADC sample present
- sample_data  in  10  ADC sample
- freeze  in  1  level; high holds buffer contents for display
- rd_req  in  1  one-cycle display read request
- rd_col  in  10  display column 0..1023 (0 = oldest sample)
- ram_we  out  1  RAM write enable
- ram_addr_in  out  10  RAM write address
- ram_din  out  10  RAM write data
- ram_addr_out  out  10  RAM read address
- ram_dout  in  10  RAM read data, valid one cycle after ram_addr_out
- rd_valid  out  1  rd_data valid strobe
- rd_data  out  10  sample returned for a read
- buf_full  out  1  1024 samples written since reset
- frozen  out  1  state is FROZEN

Function
REQ-003 The FSM SHALL have states FILL, RUN, FROZEN; reset state FILL.
REQ-004 In FILL or RUN, an accepted sample SHALL drive ram_we=1, ram_addr_in=wr_ptr, ram_din=sample_data combinationally in the same cycle, and wr_ptr SHALL increment at that edge.
REQ-005 wr_ptr SHALL be 10 bits and wrap 1023->0 with no other effect.
REQ-006 FILL->RUN SHALL occur at the edge writing address 1023 for the first time; buf_full SHALL be 1 from the next cycle until reset.
REQ-007 freeze=1 in FILL or RUN SHALL move to FROZEN at that edge; a sample arriving in the same cycle SHALL be dropped (freeze wins).
REQ-008 In FROZEN, ram_we SHALL be 0, wr_ptr SHALL hold, all samples SHALL be dropped.
REQ-009 freeze=0 in FROZEN SHALL return to RUN if buf_full else FILL, at that edge; samples in that cycle SHALL be dropped.
REQ-010 Read base SHALL be 0 in FILL and wr_ptr in RUN/FROZEN; ram_addr_out SHALL equal (base + rd_col) mod 1024, combinational.
REQ-011 rd_req in cycle N SHALL yield rd_valid=1 and rd_data=ram_dout in cycle N+1 only; rd_data SHALL be 0 when rd_valid=0.
REQ-012 Back-to-back rd_req SHALL be accepted every cycle (throughput 1/cycle); reads and writes proceed concurrently.
REQ-013 Read and write to the same address in one cycle SHALL return the newly written data.
REQ-014 rd_req with rd_col beyond written samples in FILL SHALL return whatever RAM holds; no error flag.

Reset
REQ-015 rst=1 SHALL set at the next edge: state FILL, wr_ptr=0, buf_full=0, frozen=0, rd_valid=0, rd_data=0, decimation counter=0.
REQ-016 ram_we SHALL be 0 in any cycle rst=1; a read pending when rst asserts SHALL be discarded (rd_valid=0 next cycle).
REQ-017 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-018 Macro ECG_DECIM_EN defined: a 4-bit counter SHALL count sample_valid strobes accepted in FILL/RUN; only the strobe where counter==DECIM-1 is written, counter then returns to 0; counter holds in FROZEN.
REQ-019 ECG_DECIM_EN undefined: every sample_valid in FILL/RUN SHALL be written; no decimation counter exists.

Verification
REQ-020 Reset, then 5 samples 0x001..0x005 -> ram_addr_in 0..4, wr_ptr=5, buf_full=0; rd_req rd_col=2 -> next cycle rd_valid=1, rd_data=0x003.
REQ-021 1030 samples (value=index) -> buf_full=1 after 1024th; rd_col=0 returns 6, rd_col=1023 returns 1029 (10-bit truncated: 0x005).
REQ-022 freeze=1 with sample_valid same cycle -> ram_we=0, frozen=1 next cycle; 20 more samples -> wr_ptr unchanged; freeze=0 -> RUN, writes resume.
REQ-023 rd_req every cycle for 8 cycles with rd_col 0..7 -> rd_valid high 8 consecutive cycles, data in order.
REQ-024 rst asserted cycle after rd_req, at wr_ptr=300 -> rd_valid=0, wr_ptr=0, state FILL, rd_col=0 then reads address 0.
REQ-025 ECG_DECIM_EN, DECIM=4, 12 samples -> exactly 3 writes (samples 4, 8, 12) at addresses 0,1,2.
